fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
- Sequences the synchronous instruction_memory for the core front end.
- Generates word-aligned fetch addresses and tracks the 1-cycle memory read latency.
- Buffers returned words with their PC in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts branch/jump redirects that flush buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- DEPTH, 4: instruction buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0).
- imem_en  out  1  read request to instruction_memory this cycle.
- imem_addr  out  32  byte address to instruction_memory (a); always word aligned.
- imem_rdata  in  32  instruction_memory read data (d); valid the cycle after the request.
- inst_valid  out  1  buffer head holds a valid instruction.
- inst_ready  in  1  decode accepts the head this cycle.
- inst_data  out  32  head instruction word.
- inst_pc  out  32  head instruction address.

Behaviour:
- Reset (async, rst_n=0):
  - inst_valid=0, imem_en=0, imem_addr=RESET_PC.
  - fetch_pc=RESET_PC; FIFO count=0; inflight=0; kill=0.
  - Reset mid-operation discards everything immediately.
  - First request is issued in the first cycle after rst_n deasserts.
- Memory timing: request in cycle N (imem_en=1, imem_addr=A) -> imem_rdata valid in N+1. The block registers a 1-bit inflight flag plus the request PC.
- Issue rule: imem_en=1 when no redirect this cycle and (count + inflight - pop) < DEPTH.
  - pop = inst_valid & inst_ready.
  - On issue: imem_addr=fetch_pc, and fetch_pc <= fetch_pc + 4.
  - Address wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
- Response: in cycle N+1, if inflight & ~kill, {rdata, pc} is pushed into the FIFO at the next edge. inst_valid rises in N+2 (registered head, no bypass).
- Throughput: sustained 1 instruction/cycle when inst_ready is held high (DEPTH >= 2).
- Full: no issue while the full-credit condition holds; no word is ever dropped or overwritten.
- Empty: inst_valid=0; inst_data/inst_pc are don't-care.
- Simultaneous push and pop: both take effect; count unchanged.
- Redirect in cycle R (highest priority):
  - FIFO flushed at the edge ending R; a pop in R is discarded.
  - Any response arriving in R+1 from a request made in R is dropped (kill set for one cycle).
  - No issue in R; fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - R+1: imem_en=1, imem_addr=target. R+3: inst_valid=1, inst_pc=target.
- Back-to-back redirects: the last one wins; each flushes again.
- inst_data/inst_pc stay stable while inst_valid=1 and inst_ready=0.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds output ports perf_fetch_cnt[31:0] and perf_bubble_cnt[31:0].
  - perf_fetch_cnt increments on each pop.
  - perf_bubble_cnt increments each cycle with inst_ready=1 and inst_valid=0.
  - Both are cleared by rst_n, wrap at 2^32, and are unaffected by redirect.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, inst_ready=1, memory preloaded with word = address: imem_addr 0,4,8,... each cycle. inst_valid from cycle 2; inst_pc/inst_data 0,4,8 on consecutive cycles, no bubbles.
- inst_ready=0 for 10 cycles: exactly DEPTH=4 requests issued (0,4,8,C), then imem_en=0. Head holds pc 0 stable. After inst_ready=1, pcs 0,4,8,C,10 in order, none lost.
- redirect_valid pulse with redirect_pc=32'h0000_0103 while the FIFO is full: next cycle imem_addr=32'h100. No old PC is ever presented after the redirect. First inst_pc=32'h100 two cycles later.
- Redirect on two consecutive cycles (targets 0x40 then 0x80): no instruction from 0x40 is delivered; first delivered pc=0x80.
- Redirect to 32'hFFFF_FFF8 with inst_ready=1: delivered pcs FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- rst_n asserted while inst_valid=1 with 3 entries buffered: inst_valid and imem_en drop immediately (asynchronously). After release, fetch restarts at RESET_PC. With FETCH_PERF_EN defined, both counters read 0.

Source files
------------

// File: rtl/fetch_controller.sv
// Fetch sequencer for a 1-cycle synchronous instruction memory, with a DEPTH-entry
// instruction buffer feeding decode. Define FETCH_PERF_EN to add fetch/bubble counters.
module fetch_controller #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_bubble_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW+1:0] LP_DEPTH = (AW+2)'(DEPTH);

   logic [31:0]   r_fetch_pc;
   logic          r_req_vld_p1;
   logic [31:0]   r_req_pc_p1;
   logic          r_kill_p1;
   logic [AW:0]   r_count;
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [31:0]   r_buf_data [DEPTH];
   logic [31:0]   r_buf_pc   [DEPTH];

   logic          w_pop;
   logic          w_push;
   logic          w_issue;
   logic [AW+1:0] w_occ;
   logic [31:0]   w_redirect_tgt;
   logic          w_unused;

   assign w_redirect_tgt = {redirect_pc[31:2], 2'b00};
   assign w_unused       = &{1'b0, redirect_pc[1:0]};

   // Credit check counts the in-flight word so a returning response always has a slot.
   assign inst_valid = (r_count != '0);
   assign w_pop      = inst_valid & inst_ready;
   assign w_occ      = {1'b0, r_count} + (AW+2)'(r_req_vld_p1) - (AW+2)'(w_pop);
   assign w_issue    = rst_n & ~redirect_valid & (w_occ < LP_DEPTH);
   assign w_push     = r_req_vld_p1 & ~r_kill_p1 & ~redirect_valid;

   assign imem_en   = w_issue;
   assign imem_addr = r_fetch_pc;
   assign inst_data = r_buf_data[r_rd_ptr];
   assign inst_pc   = r_buf_pc[r_rd_ptr];

   // Stage p0 -> p1: request issue; buffer control and redirect flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc   <= RESET_PC;
         r_req_vld_p1 <= 1'b0;
         r_kill_p1    <= 1'b0;
         r_count      <= '0;
         r_rd_ptr     <= '0;
         r_wr_ptr     <= '0;
      end else begin
         r_req_vld_p1 <= w_issue;
         r_kill_p1    <= redirect_valid;
         if (redirect_valid) begin
            r_fetch_pc <= w_redirect_tgt;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
         end else begin
            if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_push)  r_wr_ptr   <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr   <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
               r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
               r_count <= r_count - 1'b1;
         end
      end
   end

   // Stage p1 -> buffer: request PC travels with the memory response
   always_ff @(posedge clk) begin
      if (w_issue) r_req_pc_p1 <= r_fetch_pc;
      if (w_push) begin
         r_buf_data[r_wr_ptr] <= imem_rdata;
         r_buf_pc[r_wr_ptr]   <= r_req_pc_p1;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] r_perf_fetch;
   logic [31:0] r_perf_bubble;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_fetch  <= '0;
         r_perf_bubble <= '0;
      end else begin
         if (w_pop)                     r_perf_fetch  <= r_perf_fetch + 32'd1;
         if (inst_ready && !inst_valid) r_perf_bubble <= r_perf_bubble + 32'd1;
      end
   end

   assign perf_fetch_cnt  = r_perf_fetch;
   assign perf_bubble_cnt = r_perf_bubble;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus a randomized run checked
// against a queue-based model of the fetch buffer.
module tb_fetch_controller;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_bubble_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   fetch_controller #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_en        (imem_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_bubble_cnt(perf_bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   // Synchronous memory: data for a request appears the following cycle; junk otherwise.
   logic [31:0] mem_q = 32'hBAD0_BAD0;
   always @(posedge clk) begin
      if (imem_en) mem_q <= mem_word(imem_addr);
      else         mem_q <= 32'hBAD0_BAD0;
   end
   assign imem_rdata = mem_q;

   task automatic do_reset(input logic rdy);
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = rdy;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
      @(negedge clk);
      n_vec++;
      if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
      n_vec++;
      if (imem_en !== 1'b0) begin n_err++; $display("FAIL reset_en: got %b want 0", imem_en); end
      n_vec++;
      if (imem_addr !== RESET_PC) begin n_err++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
`ifdef FETCH_PERF_EN
      n_vec++;
      if (perf_fetch_cnt !== 32'd0 || perf_bubble_cnt !== 32'd0) begin
         n_err++; $display("FAIL reset_perf: got %h/%h want 0/0", perf_fetch_cnt, perf_bubble_cnt);
      end
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // Continues directly from test_reset's release with inst_ready held high.
   task automatic test_stream();
      logic [31:0] epc;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         n_vec++;
         if (imem_en !== 1'b1 || imem_addr !== 32'(4*c)) begin
            n_err++; $display("FAIL stream_req c%0d: got en=%b addr=%h want en=1 addr=%h", c, imem_en, imem_addr, 32'(4*c));
         end
         n_vec++;
         if (inst_valid !== (c >= 2)) begin
            n_err++; $display("FAIL stream_valid c%0d: got %b want %b", c, inst_valid, (c >= 2));
         end
         if (c >= 2) begin
            epc = 32'(4*(c-2));
            n_vec++;
            if (inst_pc !== epc || inst_data !== mem_word(epc)) begin
               n_err++; $display("FAIL stream_head c%0d: got pc=%h d=%h want pc=%h d=%h", c, inst_pc, inst_data, epc, mem_word(epc));
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stall();
      logic [31:0] epc;
      do_reset(1'b0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_vec++;
         if (imem_en !== (c < 4)) begin n_err++; $display("FAIL stall_en c%0d: got %b want %b", c, imem_en, (c < 4)); end
         if (c < 4) begin
            n_vec++;
            if (imem_addr !== 32'(4*c)) begin n_err++; $display("FAIL stall_addr c%0d: got %h want %h", c, imem_addr, 32'(4*c)); end
         end
         if (c >= 2) begin
            n_vec++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== mem_word(32'h0)) begin
               n_err++; $display("FAIL stall_hold c%0d: got v=%b pc=%h d=%h want v=1 pc=0 d=%h", c, inst_valid, inst_pc, inst_data, mem_word(32'h0));
            end
         end
         @(posedge clk); #1;
      end
      inst_ready = 1'b1;
      epc = 32'h0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         n_vec++;
         if (inst_valid !== 1'b1 || inst_pc !== epc || inst_data !== mem_word(epc)) begin
            n_err++; $display("FAIL stall_drain k%0d: got v=%b pc=%h d=%h want v=1 pc=%h", k, inst_valid, inst_pc, inst_data, epc);
         end
         epc += 32'd4;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_redirect_full();
      logic [31:0] epc;
      do_reset(1'b0);
      repeat (8) begin @(posedge clk); #1; end
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; inst_ready = 1'b1;
      @(negedge clk);
      n_vec++;
      if (imem_en !== 1'b0) begin n_err++; $display("FAIL redir_en_R: got %b want 0", imem_en); end
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) begin
            n_vec++;
            if (imem_en !== 1'b1 || imem_addr !== 32'h100) begin
               n_err++; $display("FAIL redir_target: got en=%b addr=%h want en=1 addr=00000100", imem_en, imem_addr);
            end
         end
         n_vec++;
         if (inst_valid !== (k >= 3)) begin n_err++; $display("FAIL redir_valid k%0d: got %b want %b", k, inst_valid, (k >= 3)); end
         if (k >= 3) begin
            epc = 32'h100 + 32'(4*(k-3));
            n_vec++;
            if (inst_pc !== epc || inst_data !== mem_word(epc)) begin
               n_err++; $display("FAIL redir_head k%0d: got pc=%h d=%h want pc=%h", k, inst_pc, inst_data, epc);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] epc;
      do_reset(1'b1);
      repeat (5) begin @(posedge clk); #1; end
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      @(negedge clk);
      n_vec++;
      if (imem_en !== 1'b0) begin n_err++; $display("FAIL b2b_en_R0: got %b want 0", imem_en); end
      @(posedge clk); #1;
      redirect_pc = 32'h80;
      @(negedge clk);
      n_vec++;
      if (imem_en !== 1'b0 || inst_valid !== 1'b0) begin
         n_err++; $display("FAIL b2b_R1: got en=%b v=%b want en=0 v=0", imem_en, inst_valid);
      end
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      for (int k = 2; k < 10; k++) begin
         @(negedge clk);
         if (k == 2) begin
            n_vec++;
            if (imem_en !== 1'b1 || imem_addr !== 32'h80) begin
               n_err++; $display("FAIL b2b_target: got en=%b addr=%h want en=1 addr=00000080", imem_en, imem_addr);
            end
         end
         n_vec++;
         if (inst_valid !== (k >= 4)) begin n_err++; $display("FAIL b2b_valid k%0d: got %b want %b", k, inst_valid, (k >= 4)); end
         if (k >= 4) begin
            epc = 32'h80 + 32'(4*(k-4));
            n_vec++;
            if (inst_pc !== epc || inst_data !== mem_word(epc)) begin
               n_err++; $display("FAIL b2b_head k%0d: got pc=%h want pc=%h", k, inst_pc, epc);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_wrap();
      logic [31:0] epc;
      do_reset(1'b1);
      repeat (3) begin @(posedge clk); #1; end
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k <= 4) begin
            epc = 32'hFFFF_FFF8 + 32'(4*(k-1));
            n_vec++;
            if (imem_en !== 1'b1 || imem_addr !== epc) begin
               n_err++; $display("FAIL wrap_req k%0d: got en=%b addr=%h want en=1 addr=%h", k, imem_en, imem_addr, epc);
            end
         end
         if (k >= 3) begin
            epc = 32'hFFFF_FFF8 + 32'(4*(k-3));
            n_vec++;
            if (inst_valid !== 1'b1 || inst_pc !== epc || inst_data !== mem_word(epc)) begin
               n_err++; $display("FAIL wrap_head k%0d: got v=%b pc=%h want v=1 pc=%h", k, inst_valid, inst_pc, epc);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      do_reset(1'b1);
      repeat (3) begin @(posedge clk); #1; end
      inst_ready = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      #2;
      n_vec++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin
         n_err++; $display("FAIL rstmid_pre: got v=%b pc=%h want v=1 pc=00000004", inst_valid, inst_pc);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (inst_valid !== 1'b0 || imem_en !== 1'b0) begin
         n_err++; $display("FAIL rstmid_async: got v=%b en=%b want 0/0", inst_valid, imem_en);
      end
`ifdef FETCH_PERF_EN
      n_vec++;
      if (perf_fetch_cnt !== 32'd0 || perf_bubble_cnt !== 32'd0) begin
         n_err++; $display("FAIL rstmid_perf: got %h/%h want 0/0", perf_fetch_cnt, perf_bubble_cnt);
      end
`endif
      @(posedge clk); #1;
      rst_n = 1'b1; inst_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_vec++;
         if (imem_en !== 1'b1 || imem_addr !== RESET_PC + 32'(4*c)) begin
            n_err++; $display("FAIL rstmid_restart c%0d: got en=%b addr=%h want en=1 addr=%h", c, imem_en, imem_addr, RESET_PC + 32'(4*c));
         end
         n_vec++;
         if (inst_valid !== (c >= 2) || (c >= 2 && inst_pc !== RESET_PC + 32'(4*(c-2)))) begin
            n_err++; $display("FAIL rstmid_head c%0d: got v=%b pc=%h", c, inst_valid, inst_pc);
         end
         @(posedge clk); #1;
      end
   endtask

   // Model: a queue of buffered PCs, one pending request slot and a fetch pointer.
   task automatic test_random();
      logic [31:0] m_q[$];
      logic [31:0] m_fetch_pc;
      logic        m_inf;
      logic [31:0] m_inf_pc;
      logic [31:0] m_perf_fetch;
      logic [31:0] m_perf_bubble;
      logic        e_valid, e_pop, e_en;
      logic [31:0] tgt;
      int          ready_pct;
      do_reset(1'b0);
      m_q.delete();
      m_fetch_pc = RESET_PC; m_inf = 1'b0; m_inf_pc = '0;
      m_perf_fetch = '0; m_perf_bubble = '0;
      ready_pct = 75;
      for (int cyc = 0; cyc < 800; cyc++) begin
         if (cyc % 50 == 0) ready_pct = (ready_pct == 75) ? 20 : 75;
         redirect_valid = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 2))
            0:       redirect_pc = $urandom;
            1:       redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: redirect_pc = 32'($urandom_range(0, 255));
         endcase
         inst_ready = ($urandom_range(0, 99) < ready_pct);
         @(negedge clk);
         e_valid = (m_q.size() > 0);
         e_pop   = e_valid & inst_ready;
         e_en    = !redirect_valid && (m_q.size() + int'(m_inf) - int'(e_pop) < DEPTH);
         n_vec++;
         if (imem_en !== e_en) begin n_err++; $display("FAIL rand_en cyc%0d: got %b want %b", cyc, imem_en, e_en); end
         if (e_en) begin
            n_vec++;
            if (imem_addr !== m_fetch_pc) begin n_err++; $display("FAIL rand_addr cyc%0d: got %h want %h", cyc, imem_addr, m_fetch_pc); end
         end
         n_vec++;
         if (inst_valid !== e_valid) begin n_err++; $display("FAIL rand_valid cyc%0d: got %b want %b", cyc, inst_valid, e_valid); end
         if (e_valid) begin
            n_vec++;
            if (inst_pc !== m_q[0] || inst_data !== mem_word(m_q[0])) begin
               n_err++; $display("FAIL rand_head cyc%0d: got pc=%h d=%h want pc=%h d=%h", cyc, inst_pc, inst_data, m_q[0], mem_word(m_q[0]));
            end
         end
`ifdef FETCH_PERF_EN
         n_vec++;
         if (perf_fetch_cnt !== m_perf_fetch || perf_bubble_cnt !== m_perf_bubble) begin
            n_err++; $display("FAIL rand_perf cyc%0d: got %h/%h want %h/%h", cyc, perf_fetch_cnt, perf_bubble_cnt, m_perf_fetch, m_perf_bubble);
         end
`endif
         if (e_pop) m_perf_fetch += 32'd1;
         if (inst_ready && !e_valid) m_perf_bubble += 32'd1;
         if (redirect_valid) begin
            m_q.delete();
            tgt = redirect_pc;
            tgt[1:0] = 2'b00;
            m_fetch_pc = tgt;
            m_inf = 1'b0;
         end else begin
            if (e_pop) void'(m_q.pop_front());
            if (m_inf) m_q.push_back(m_inf_pc);
            m_inf = e_en;
            m_inf_pc = m_fetch_pc;
            if (e_en) m_fetch_pc += 32'd4;
         end
         @(posedge clk); #1;
      end
      redirect_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
      #1;
      test_reset();
      test_stream();
      test_stall();
      test_redirect_full();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
